// File: rtl/ysyx_040978_div_ctrl.sv
// rtl/ysyx_040978_div_ctrl.sv - M-extension divide/remainder controller for the iterative 64-bit divider
// Optional YSYX_040978_DIV_FASTPATH_EN: divide-by-zero and signed overflow bypass the divider.
module ysyx_040978_div_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_word,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        div_in_valid,
  output logic        div_signed,
  output logic [63:0] div_dividend,
  output logic [63:0] div_divisor,
  input  logic        div_out_valid,
  input  logic [63:0] div_quotient,
  input  logic [63:0] div_remainder
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

  state_t      state;
  logic        rem_op;
  logic        word_op;
  logic        dz;
  logic        ovf;

  logic        req_signed;
  logic [63:0] eff_a;
  logic [63:0] eff_b;
  logic        req_dz;
  logic        req_ovf;

  // Override for the two cases the divider cannot answer architecturally, then W sign-extension.
  function automatic logic [63:0] fix_result(input logic rem, input logic word, input logic zero,
                                             input logic over, input logic [63:0] q,
                                             input logic [63:0] r, input logic [63:0] a);
    logic [63:0] res;
    res = rem ? r : q;
    if (zero)
      res = rem ? a : {64{1'b1}};
    else if (over)
      res = rem ? 64'd0 : a;
    if (word)
      res = {{32{res[31]}}, res[31:0]};
    return res;
  endfunction

  assign req_ready    = (state == IDLE) & ~flush;
  assign div_in_valid = (state == ISSUE) & ~flush;

  always_comb begin
    req_signed = ~req_op[0];
    eff_a      = req_src1;
    eff_b      = req_src2;
    if (req_word) begin
      eff_a = {{32{req_signed & req_src1[31]}}, req_src1[31:0]};
      eff_b = {{32{req_signed & req_src2[31]}}, req_src2[31:0]};
    end
    req_dz  = (eff_b == 64'd0);
    req_ovf = req_signed && (eff_b == {64{1'b1}}) &&
              (eff_a == (req_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  end

`ifdef YSYX_040978_DIV_FASTPATH_EN
  logic [63:0] fast_data;
  always_comb begin
    fast_data = fix_result(req_op[1], req_word, req_dz, req_ovf, 64'd0, 64'd0, eff_a);
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      resp_valid   <= 1'b0;
      resp_data    <= 64'd0;
      div_signed   <= 1'b0;
      div_dividend <= 64'd0;
      div_divisor  <= 64'd0;
      rem_op       <= 1'b0;
      word_op      <= 1'b0;
      dz           <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            rem_op       <= req_op[1];
            word_op      <= req_word;
            div_signed   <= req_signed;
            div_dividend <= eff_a;
            div_divisor  <= eff_b;
            dz           <= req_dz;
            ovf          <= req_ovf;
`ifdef YSYX_040978_DIV_FASTPATH_EN
            if (req_dz || req_ovf) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= fast_data;
            end else begin
              state <= ISSUE;
            end
`else
            state <= ISSUE;
`endif
          end
        end
        ISSUE: state <= flush ? IDLE : WAIT;
        WAIT: begin
          if (flush) begin
            // An issued divide cannot be aborted; DRAIN soaks up its result.
            state <= div_out_valid ? IDLE : DRAIN;
          end else if (div_out_valid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= fix_result(rem_op, word_op, dz, ovf, div_quotient, div_remainder,
                                     div_dividend);
          end
        end
        RESP: begin
          if (flush || resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (div_out_valid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
